// File: rtl/wave_shaper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wave_shaper_pkg
// Brief    : Shared state encodings, mode constants and saturating helpers
// Revision : 1.0 - initial release
// ============================================================================
package wave_shaper_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WARMUP  = 2'd0;
    localparam state_t ST_MEASURE = 2'd1;
    localparam state_t ST_COMMIT  = 2'd2;
    localparam state_t ST_LOCKED  = 2'd3;

    localparam logic MODE_TRI = 1'b0;
    localparam logic MODE_SQR = 1'b1;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a < b) ? 32'd0 : (a - b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_shaper_cal_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_shaper_cal_if
// Brief    : Sample stream, control and status bundle for wave_shaper_cal
// Revision : 1.0 - initial release
// ============================================================================
interface wave_shaper_cal_if #(
    parameter int DATA_W = 10,
    parameter int OUT_W  = 10,
    parameter int STEP_W = 4
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              mode;
    logic [STEP_W-1:0] step;
    logic              recal;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic [DATA_W-1:0] threshold;
    logic              locked;
    logic              cal_fail;

    modport master (
        output in_valid, in_data, mode, step, recal,
        input  out_valid, out_data, threshold, locked, cal_fail
    );

    modport slave (
        input  in_valid, in_data, mode, step, recal,
        output out_valid, out_data, threshold, locked, cal_fail
    );
endinterface
`default_nettype wire

// File: rtl/wave_extremum_tracker.sv
`default_nettype none
// ============================================================================
// Module   : wave_extremum_tracker
// Brief    : 3-sample window peak/trough detector with max/min accumulators
// Revision : 1.0 - initial release
// ============================================================================
module wave_extremum_tracker #(
    parameter int DATA_W = 10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_valid,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_clear,
    input  wire logic              i_acc_en,
    output logic      [DATA_W-1:0] o_max,
    output logic      [DATA_W-1:0] o_min,
    output logic                   o_peak_seen,
    output logic                   o_trough_seen
);
    // The incoming sample acts as s0, so the window ending on it is judged in the same cycle.
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic [1:0]        r_fill;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic              r_peak_seen;
    logic              r_trough_seen;

    logic w_full;
    logic w_peak;
    logic w_trough;

    assign w_full   = (r_fill == 2'd2);
    assign w_peak   = w_full && (r_s1 > i_data) && (r_s1 >= r_s2);
    assign w_trough = w_full && (r_s1 < i_data) && (r_s1 <= r_s2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_fill        <= 2'd0;
            r_max         <= '0;
            r_min         <= '0;
            r_peak_seen   <= 1'b0;
            r_trough_seen <= 1'b0;
        end else begin
            if (i_valid) begin
                r_s1 <= i_data;
                r_s2 <= r_s1;
            end
            if (i_clear) begin
                r_fill        <= 2'd0;
                r_max         <= '0;
                r_min         <= '1;
                r_peak_seen   <= 1'b0;
                r_trough_seen <= 1'b0;
            end else if (i_valid) begin
                if (!w_full) begin
                    r_fill <= r_fill + 2'd1;
                end
                if (i_acc_en && w_peak) begin
                    r_peak_seen <= 1'b1;
                    if (r_s1 > r_max) begin
                        r_max <= r_s1;
                    end
                end
                if (i_acc_en && w_trough) begin
                    r_trough_seen <= 1'b1;
                    if (r_s1 < r_min) begin
                        r_min <= r_s1;
                    end
                end
            end
        end
    end

    assign o_max         = r_max;
    assign o_min         = r_min;
    assign o_peak_seen   = r_peak_seen;
    assign o_trough_seen = r_trough_seen;

endmodule
`default_nettype wire

// File: rtl/wave_shaper_cal.sv
`default_nettype none
// ============================================================================
// Module   : wave_shaper_cal
// Brief    : Self-calibrating triangle/square shaper locked to input crossings
// Revision : 1.0 - initial release
// ============================================================================
module wave_shaper_cal
    import wave_shaper_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int OUT_W     = 10,
    parameter int STEP_W    = 4,
    parameter int WARMUP    = 16,
    parameter int CAL_LEN   = 512,
    parameter int RECAL_PER = 0
) (
    input  wire logic        clk,
    input  wire logic        sys_rst,
    wave_shaper_cal_if.slave bus
);
    localparam int CNT_MAX0 = (WARMUP > CAL_LEN) ? WARMUP : CAL_LEN;
    localparam int CNT_MAX  = (RECAL_PER > CNT_MAX0) ? RECAL_PER : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_WU_LAST  = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNT_W-1:0] c_CAL_LAST = CNT_W'(CAL_LEN - 1);
    localparam logic [CNT_W-1:0] c_RP_LAST  = CNT_W'((RECAL_PER > 0) ? RECAL_PER - 1 : 0);
    localparam logic [31:0]      c_OUT_MAX  = 32'((64'd1 << OUT_W) - 64'd1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_thr;
    logic              r_locked;
    logic              r_cal_fail;
    logic [OUT_W-1:0]  r_acc;
    logic [OUT_W-1:0]  r_out;
    logic              r_out_valid;

    logic              w_wu_done;
    logic              w_win_done;
    logic              w_recal_due;
    logic              w_relaunch;
    logic              w_clear;
    logic              w_acc_en;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_min;
    logic              w_peak_seen;
    logic              w_trough_seen;
    logic [DATA_W:0]   w_sum;
    logic              w_cal_ok;
    logic              w_above;
    logic [OUT_W-1:0]  w_acc_next;

    assign w_wu_done   = (r_state == ST_WARMUP) && bus.in_valid && (r_cnt == c_WU_LAST);
    assign w_win_done  = (r_state == ST_MEASURE) && !bus.recal && bus.in_valid
                         && (r_cnt == c_CAL_LAST);
    assign w_recal_due = (RECAL_PER != 0) && bus.in_valid && (r_cnt == c_RP_LAST);
    assign w_relaunch  = (r_state == ST_LOCKED) && (bus.recal || w_recal_due);
    assign w_clear     = w_wu_done || ((r_state == ST_MEASURE) && bus.recal) || w_relaunch;
    assign w_acc_en    = (r_state == ST_MEASURE) && !bus.recal;

    wave_extremum_tracker #(
        .DATA_W (DATA_W)
    ) u_tracker (
        .clk           (clk),
        .rst           (sys_rst),
        .i_valid       (bus.in_valid),
        .i_data        (bus.in_data),
        .i_clear       (w_clear),
        .i_acc_en      (w_acc_en),
        .o_max         (w_max),
        .o_min         (w_min),
        .o_peak_seen   (w_peak_seen),
        .o_trough_seen (w_trough_seen)
    );

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_WARMUP;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    if (bus.in_valid) begin
                        if (w_wu_done) begin
                            r_state <= ST_MEASURE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (bus.recal) begin
                        r_cnt <= '0;
                    end else if (bus.in_valid) begin
                        if (w_win_done) begin
                            r_state <= ST_COMMIT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_LOCKED;
                    r_cnt   <= '0;
                end
                ST_LOCKED: begin
                    if (w_relaunch) begin
                        r_state <= ST_MEASURE;
                        r_cnt   <= '0;
                    end else if (bus.in_valid && (RECAL_PER != 0)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_WARMUP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Midpoint needs one extra bit so max+min cannot overflow before the halving.
    assign w_sum    = {1'b0, w_max} + {1'b0, w_min};
    assign w_cal_ok = w_peak_seen && w_trough_seen && (w_max >= w_min);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_thr      <= '0;
            r_locked   <= 1'b0;
            r_cal_fail <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            if (w_cal_ok) begin
                r_thr      <= DATA_W'(w_sum >> 1);
                r_locked   <= 1'b1;
                r_cal_fail <= 1'b0;
            end else begin
                r_cal_fail <= 1'b1;
            end
        end
    end

    assign w_above    = (bus.in_data >= r_thr);
    assign w_acc_next = w_above ? OUT_W'(sat_add(32'(r_acc), 32'(bus.step), c_OUT_MAX))
                                : OUT_W'(sat_sub(32'(r_acc), 32'(bus.step)));

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid && r_locked;
            if (bus.in_valid && r_locked) begin
                r_acc <= w_acc_next;
                r_out <= (bus.mode == MODE_SQR) ? {OUT_W{w_above}} : w_acc_next;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out;
    assign bus.threshold = r_thr;
    assign bus.locked    = r_locked;
    assign bus.cal_fail  = r_cal_fail;

endmodule
`default_nettype wire

// File: tb/tb_wave_shaper_cal.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_shaper_cal
// Brief    : Randomised self-checking bench with a window-scanning reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_shaper_cal;
    localparam int DW  = 10;
    localparam int OW  = 10;
    localparam int SW  = 4;
    localparam int WU  = 16;
    localparam int CL  = 512;
    localparam int TOP = (1 << OW) - 1;
    localparam int N1  = WU + CL + 1 + 200;

    logic clk     = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

    wave_shaper_cal_if #(.DATA_W(DW), .OUT_W(OW), .STEP_W(SW)) bus ();

    wave_shaper_cal #(
        .DATA_W(DW), .OUT_W(OW), .STEP_W(SW),
        .WARMUP(WU), .CAL_LEN(CL), .RECAL_PER(0)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 warmup, 1 measure, 2 commit, 3 locked
    int m_phase, m_wu_cnt, m_thr, m_acc, m_out;
    bit m_locked, m_fail, m_outv;
    int win[$];
    int phs;
    int ref_thr;

    logic [22:0] dut_vec;
    assign dut_vec = {bus.out_valid, bus.out_data, bus.threshold, bus.locked, bus.cal_fail};

    function automatic logic [22:0] exp_vec();
        return {m_outv, OW'(m_out), DW'(m_thr), m_locked, m_fail};
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_wu_cnt = 0; m_thr = 0; m_acc = 0; m_out = 0;
        m_locked = 0; m_fail = 0; m_outv = 0;
        win.delete();
    endfunction

    function automatic void model_commit();
        int mx = -1;
        int mn = 1 << 30;
        bit pk = 0;
        bit tr = 0;
        for (int i = 1; i < win.size() - 1; i++) begin
            if (win[i] > win[i+1] && win[i] >= win[i-1]) begin
                pk = 1;
                if (win[i] > mx) mx = win[i];
            end
            if (win[i] < win[i+1] && win[i] <= win[i-1]) begin
                tr = 1;
                if (win[i] < mn) mn = win[i];
            end
        end
        if (pk && tr && mx >= mn) begin
            m_thr = (mx + mn) / 2; m_locked = 1; m_fail = 0;
        end else begin
            m_fail = 1;
        end
    endfunction

    function automatic void model_step(bit v, int d, bit r, bit mode, int stp);
        bit above;
        if (v && m_locked) begin
            above = (d >= m_thr);
            if (above) m_acc = (m_acc + stp > TOP) ? TOP : m_acc + stp;
            else       m_acc = (m_acc < stp) ? 0 : m_acc - stp;
            m_out = mode ? (above ? TOP : 0) : m_acc;
        end
        m_outv = v && m_locked;
        case (m_phase)
            0: if (v) begin
                m_wu_cnt++;
                if (m_wu_cnt == WU) begin m_phase = 1; win.delete(); end
            end
            1: if (r) win.delete();
               else if (v) begin
                   win.push_back(d);
                   if (win.size() == CL) m_phase = 2;
               end
            2: begin model_commit(); m_phase = 3; end
            default: if (r) begin m_phase = 1; win.delete(); end
        endcase
    endfunction

    function automatic int sine(int i, int amp, int mid);
        real x;
        x = 2.0 * 3.14159265358979 * real'(i + phs) / 64.0;
        return mid + $rtoi($floor(real'(amp) * $sin(x) + 0.5));
    endfunction

    task automatic cyc(input bit v, input int d, input bit r);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = DW'(d);
        bus.recal    = r;
        @(posedge clk);
        model_step(v, d, r, bus.mode, int'(bus.step));
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.recal    = 1'b0;
        sys_rst      = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_data = 10'd700; bus.mode = 1'b0;
        bus.step = 4'd1; bus.recal = 1'b0;
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_data = DW'($urandom_range(0, TOP));
            checks++;
            if (dut_vec !== 23'd0) begin
                errors++;
                $display("FAIL reset_state: got %h want 0", dut_vec);
            end
        end
    endtask

    task automatic test_sine_lock();
        phs = $urandom_range(0, 63);
        bus.mode = 1'b0; bus.step = 4'd1;
        release_reset();
        for (int i = 0; i < N1; i++) begin
            cyc(1'b1, sine(i, 200, 512), 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sine_lock cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == WU + CL - 1) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_early: got %b want 0", bus.locked);
                end
            end
            if (i == WU + CL) begin
                checks++;
                if (bus.locked !== 1'b1 || bus.threshold < 511 || bus.threshold > 513) begin
                    errors++;
                    $display("FAIL lock_time: locked %b thr %0d want 1 / 512+-1",
                             bus.locked, bus.threshold);
                end
            end
        end
        ref_thr = m_thr;
    endtask

    task automatic test_saturation();
        bus.mode = 1'b0; bus.step = 4'd15;
        for (int i = 0; i < 160; i++) begin
            cyc(1'b1, (i < 80) ? 1000 : 0, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL saturation cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 79 || i == 159) begin
                checks++;
                if (bus.out_data !== ((i == 79) ? OW'(TOP) : OW'(0))) begin
                    errors++;
                    $display("FAIL sat_rail cyc %0d: got %0d want %0d", i, bus.out_data,
                             (i == 79) ? TOP : 0);
                end
            end
        end
    endtask

    task automatic test_square();
        bus.mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            bus.step = SW'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, TOP), 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL square cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (bus.out_valid) begin
                checks++;
                if (bus.out_data !== OW'(0) && bus.out_data !== OW'(TOP)) begin
                    errors++;
                    $display("FAIL square_level: got %0d want 0 or %0d", bus.out_data, TOP);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.mode = 1'($urandom_range(0, 1));
            bus.step = SW'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, TOP), 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_recal();
        int old_thr;
        old_thr = int'(bus.threshold);
        bus.mode = 1'b0; bus.step = 4'd1;
        cyc(1'b1, sine(0, 200, 512), 1'b1);
        for (int i = 0; i < CL + 40; i++) begin
            cyc(1'b1, sine(i, 100, 400), 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL recal cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == CL - 1) begin
                checks++;
                if (int'(bus.threshold) != old_thr || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL recal_hold: thr %0d valid %b want %0d / 1",
                             bus.threshold, bus.out_valid, old_thr);
                end
            end
        end
        checks++;
        if (bus.threshold < 399 || bus.threshold > 401 || bus.cal_fail !== 1'b0) begin
            errors++;
            $display("FAIL recal_new_thr: thr %0d fail %b want 400+-1 / 0",
                     bus.threshold, bus.cal_fail);
        end
    endtask

    task automatic test_reset_mid_measure();
        bus.mode = 1'b1;
        cyc(1'b1, 400, 1'b1);
        for (int i = 0; i < 100; i++) cyc(1'b1, sine(i, 100, 400), 1'b0);
        #2;
        bus.in_valid = 1'b0;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 23'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want 0", dut_vec);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec !== 23'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h want 0", dut_vec);
        end
    endtask

    task automatic test_const_fail();
        bit saw_valid = 1'b0;
        bus.mode = 1'b0; bus.step = 4'd3;
        release_reset();
        for (int i = 0; i < WU + CL + 31; i++) begin
            cyc(1'b1, 300, 1'b0);
            if (bus.out_valid) saw_valid = 1'b1;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL const cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (bus.cal_fail !== 1'b1 || bus.locked !== 1'b0 || saw_valid) begin
            errors++;
            $display("FAIL const_status: fail %b locked %b valid_seen %b want 1/0/0",
                     bus.cal_fail, bus.locked, saw_valid);
        end
    endtask

    task automatic test_stretched();
        int k = 0;
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        bus.mode = 1'b0; bus.step = 4'd1;
        release_reset();
        for (int c = 0; c < 3 * N1 + 3 && k < N1; c++) begin
            if (c % 3 == 2) begin
                cyc(1'b1, sine(k, 200, 512), 1'b0);
                k++;
            end else begin
                cyc(1'b0, $urandom_range(0, TOP), 1'b0);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL stretched cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        checks++;
        if (int'(bus.threshold) != ref_thr || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL stretched_thr: thr %0d locked %b want %0d / 1",
                     bus.threshold, bus.locked, ref_thr);
        end
    endtask

    initial begin
        test_reset();
        test_sine_lock();
        test_saturation();
        test_square();
        test_random();
        test_recal();
        test_reset_mid_measure();
        test_const_fail();
        test_stretched();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
